// File: rtl/prog_loader.sv
// prog_loader: boot-time feeder that streams 32-bit words into the core's byte memory
// (big-endian, from address 0) and holds the core in reset until the load completes.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running mod-2^32 sum of accepted words).
module prog_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

  localparam logic [ADDR_W-2:0] WC_MAX = (ADDR_W-1)'(MAX_WORDS);

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        bc;
  logic [31:0]       data_q;
  logic              last_q;
  logic              hs;
  logic              arm;

  // Big-endian byte lane: index 0 is the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign in_ready = (state == ACCEPT);
  assign hs       = in_ready & in_valid;
  assign arm      = start & ((state == IDLE) | (state == DONE));

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start)    state_d = ACCEPT;
      ACCEPT:     if (in_valid) state_d = WRITE;
      WRITE: begin
        if (bc == 2'd3) begin
          if (last_q)                    state_d = DONE;
          else if (word_count == WC_MAX) state_d = ERR;
          else                           state_d = ACCEPT;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bc         <= '0;
      ptr        <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state     <= state_d;
      cpu_reset <= (state_d != DONE);
      busy      <= (state_d == ACCEPT) || (state_d == WRITE);
      done      <= (state_d == DONE);
      error     <= (state_d == ERR);
      mem_we    <= (state_d == WRITE);
      if (arm) begin
        ptr        <= '0;
        word_count <= '0;
      end
      if (hs) begin
        bc         <= 2'd0;
        word_count <= word_count + (ADDR_W-1)'(1);
        mem_addr   <= ptr;
        mem_wdata  <= in_data[31:24];
      end else if (state == WRITE) begin
        bc <= bc + 2'd1;
        if (bc != 2'd3) begin
          mem_addr  <= mem_addr + ADDR_W'(1);
          mem_wdata <= byte_sel(data_q, bc + 2'd1);
        end else begin
          ptr <= ptr + ADDR_W'(4);
        end
      end
    end
  end

  // Word payload carries no reset; it is only read after a handshake has loaded it.
  always_ff @(posedge clk) begin
    if (hs) begin
      data_q <= in_data;
      last_q <= in_last;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    checksum <= '0;
    else if (arm) checksum <= '0;
    else if (hs)  checksum <= checksum + in_data;
  end
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a small-memory build (ADDR_W=4) checked against
// a word-list / byte-image reference model of the load protocol.
module tb_prog_loader;
  localparam int AW   = 4;
  localparam int MAXW = 2 ** (AW - 2);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [31:0] CK_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CK_MASK = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [31:0]   in_data;
  logic          in_ready, mem_we, cpu_reset, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [AW-2:0] word_count;
  logic [31:0]   checksum;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          wr_cnt = 0;
  logic [7:0]  tb_mem [0:2**AW-1];
  logic [31:0] prog [0:MAXW-1];
  logic [31:0] sum;

  // Behaves like the core's memory: captures the byte presented during each write cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [7:0] model_byte(input logic [31:0] w, input int k);
    return 8'(w >> (8 * (3 - k)));
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpurst"}, cpu_reset, 1);
    chk({tag, "_ready"},  in_ready, 0);
    chk({tag, "_we"},     mem_we, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_err"},    error, 0);
    chk({tag, "_addr"},   mem_addr, 0);
    chk({tag, "_wdata"},  mem_wdata, 0);
    chk({tag, "_wc"},     word_count, 0);
    chk({tag, "_ck"},     checksum, 0);
  endtask

  // Runs one load of prog[0..n-1]; entered and left at a falling edge.
  task automatic load(input int n, input int gap, input bit with_last, input bit valid_at_start);
    int base_wr;
    sum      = 0;
    start    = 1'b1;
    in_valid = valid_at_start;
    in_data  = prog[0];
    in_last  = with_last && (n == 1);
    @(negedge clk);
    start   = 1'b0;
    base_wr = wr_cnt;
    chk("arm_ready", in_ready, 1);
    chk("arm_wc", word_count, 0);
    chk("arm_cpurst", cpu_reset, 1);
    chk("arm_done", done, 0);
    chk("arm_we", mem_we, 0);
    chk("arm_ck", checksum, 0);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("gap_we_w%0d", i), mem_we, 0);
        chk($sformatf("gap_ready_w%0d", i), in_ready, 1);
        chk($sformatf("gap_wc_w%0d", i), word_count, i);
      end
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = with_last && (i == n - 1);
      chk($sformatf("hs_ready_w%0d", i), in_ready, 1);
      @(negedge clk);
      sum += prog[i];
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("we_w%0d_b%0d", i, k), mem_we, 1);
        chk($sformatf("addr_w%0d_b%0d", i, k), mem_addr, 4 * i + k);
        chk($sformatf("data_w%0d_b%0d", i, k), mem_wdata, model_byte(prog[i], k));
        chk($sformatf("rdy_w%0d_b%0d", i, k), in_ready, 0);
        chk($sformatf("busy_w%0d_b%0d", i, k), busy, 1);
        if (k == 0) begin
          chk($sformatf("wc_w%0d", i), word_count, i + 1);
          chk($sformatf("ck_w%0d", i), checksum, sum & CK_MASK);
        end
        start    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk($sformatf("post_we_w%0d", i), mem_we, 0);
      chk($sformatf("hold_addr_w%0d", i), mem_addr, 4 * i + 3);
      chk($sformatf("hold_data_w%0d", i), mem_wdata, model_byte(prog[i], 3));
      if (with_last && i == n - 1) begin
        chk("end_done", done, 1);
        chk("end_cpurst", cpu_reset, 0);
        chk("end_busy", busy, 0);
        chk("end_err", error, 0);
      end else if (i + 1 == MAXW) begin
        chk("ovf_err", error, 1);
        chk("ovf_cpurst", cpu_reset, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_busy", busy, 0);
      end else begin
        chk($sformatf("next_ready_w%0d", i), in_ready, 1);
        chk($sformatf("next_busy_w%0d", i), busy, 1);
        chk($sformatf("next_done_w%0d", i), done, 0);
      end
    end
    chk("wr_count", wr_cnt - base_wr, 4 * n);
    if (with_last) begin
      for (int j = 0; j < 4 * n; j++)
        chk($sformatf("mem_%0d", j), tb_mem[j], model_byte(prog[j / 4], j % 4));
      repeat (2) @(negedge clk);
      chk("stable_done", done, 1);
      chk("stable_cpurst", cpu_reset, 0);
      chk("stable_wc", word_count, n);
      chk("stable_ck", checksum, sum & CK_MASK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    // A word offered while idle must not be taken.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", in_ready, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_wc", word_count, 0);
    chk("idle_cpurst", cpu_reset, 1);
    in_valid = 1'b0;

    // Single word, start coinciding with in_valid.
    prog[0] = 32'h8C010004;
    load(1, 0, 1'b1, 1'b1);

    // Reload from DONE: three words with 3-cycle gaps.
    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    load(3, 3, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      load(n, $urandom_range(0, 2), 1'b1, 1'b0);
    end

    // Last word exactly at capacity completes normally.
    for (int i = 0; i < MAXW; i++) prog[i] = $urandom;
    load(MAXW, 1, 1'b1, 1'b0);

    // Overflow: capacity reached with no last marker.
    for (int i = 0; i < MAXW; i++) prog[i] = $urandom;
    load(MAXW, 0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("err_ready", in_ready, 0);
      chk("err_we", mem_we, 0);
      chk("err_flag", error, 1);
      chk("err_cpurst", cpu_reset, 1);
      chk("err_wc", word_count, MAXW);
    end
    in_valid = 1'b0; start = 1'b0;

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;

    // Reset while the third byte of a word is on the port.
    prog[0] = 32'hA1B2C3D4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = prog[0]; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_we", mem_we, 1);
    chk("mid_addr", mem_addr, 2);
    chk("mid_data", mem_wdata, 8'hC3);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midwr");
    @(negedge clk);
    reset = 1'b0;
    prog[0] = $urandom;
    load(1, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream feeder for the multicycle MIPS core. Accepts a stream of 32-bit instruction/data words over a valid/ready handshake and writes each one into the core's byte-addressed memory as four big-endian bytes, starting at address 0. The core is held in reset until the load completes, then released. The loader replaces hierarchical preloading of `Mem[]` with a synthesizable boot path.

## Interface
- `ADDR_W`, default 9: byte-address width of the memory port. Memory depth is 2^ADDR_W bytes.
- `MAX_WORDS`, default 2^(ADDR_W-2): maximum number of words per load.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins a load.
- `in_valid` input 1: `in_data` / `in_last` are valid.
- `in_data` input 32: word to store.
- `in_last` input 1: marks the final word of the program.
- `in_ready` output 1: loader accepts a word this cycle.
- `mem_we` output 1: byte write strobe to the core memory.
- `mem_addr` output ADDR_W: byte address.
- `mem_wdata` output 8: byte to write.
- `cpu_reset` output 1: reset to the core; OR'd with the system reset at top level.
- `busy` output 1: load in progress.
- `done` output 1: load completed successfully.
- `error` output 1: overflow; `MAX_WORDS` was reached without `in_last`.
- `word_count` output ADDR_W-1: number of words accepted in the current load.
- `checksum` output 32: see Configuration.

## Operation
- **States**
  - IDLE: `cpu_reset`=1.
  - ACCEPT: `in_ready`=1, `busy`=1.
  - WRITE: byte counter `bc` counts 0..3; `busy`=1.
  - DONE: `done`=1, `cpu_reset`=0.
  - ERR: `error`=1, `cpu_reset`=1.
- **Transitions**
  - IDLE → ACCEPT when `start`=1. This clears `word_count`, the address pointer and `checksum`.
  - ACCEPT → WRITE on handshake (`in_valid`=1 while `in_ready`=1). The word and `in_last` are latched, and `word_count` increments.
  - WRITE emits one byte per cycle:
    - `bc`=0 writes `data[31:24]` to `ptr`.
    - `bc`=1 writes `data[23:16]` to `ptr+1`.
    - `bc`=2 writes `data[15:8]` to `ptr+2`.
    - `bc`=3 writes `data[7:0]` to `ptr+3`.
    - `ptr` advances by 4 after `bc`=3.
  - WRITE after `bc`=3:
    - latched last=1 → DONE;
    - otherwise `word_count` == `MAX_WORDS` → ERR;
    - otherwise → ACCEPT.
  - DONE → ACCEPT when `start`=1, re-arming the load. `cpu_reset` is reasserted the same cycle the state changes.
  - ERR is left only by `reset`.
- **Ignored inputs**
  - `start` is ignored in ACCEPT, WRITE and ERR.
  - `in_valid` is ignored outside ACCEPT.
- **Outputs when not writing:** `mem_we`=0 except in WRITE. When `mem_we`=0, `mem_addr` and `mem_wdata` hold their last values.
- **Address width:** `ptr` is ADDR_W bits. It never wraps, because ERR is reached first when `MAX_WORDS` = 2^(ADDR_W-2).

## Timing
- **Reset values (asynchronous):**
  - state=IDLE
  - `cpu_reset`=1
  - `in_ready`, `mem_we`, `busy`, `done`, `error` = 0
  - `mem_addr`, `mem_wdata`, `word_count`, `checksum` = 0
- **Output registering:** all outputs are registered, except `in_ready`, which is decoded from state (state==ACCEPT).
- **Write latency:** the handshake occurs in cycle N; bytes are written in cycles N+1 through N+4.
- **Throughput:** 1 word per 5 cycles. The next handshake is possible no earlier than N+5.
- **Completion:** `done` rises and `cpu_reset` falls at the edge ending the 4th byte of the last word, and both remain stable while in DONE.
- **Reset during a load:** immediate return to IDLE. A partially written word stays in memory and is not rolled back.
- **`start` and `in_valid` in the same IDLE cycle:** only the transition occurs; the word is not accepted until ACCEPT.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates a mod-2^32 sum of each accepted word, updated in the handshake cycle.
  - The sum is cleared on `start`.
- `PROG_LOADER_CHECKSUM_EN` not defined:
  - The accumulator is not built.
  - `checksum` is tied to 32'h0.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock edge → all outputs take their reset values immediately; `cpu_reset`=1.
- **Single-word load:** `start`, then word 32'h8C010004 with `in_last`=1 → bytes 8C, 01, 00, 04 written to addresses 0..3 on 4 consecutive cycles; `done`=1 and `cpu_reset`=0 on the next cycle; `word_count`=1.
- **Three-word load with gaps:** three words, with `in_valid` deasserted for 3 cycles between words → addresses 0..11 written in order; no write while `in_valid`=0; with the macro defined, `checksum` equals the sum of the three words.
- **Overflow:** `ADDR_W`=4 (`MAX_WORDS`=4); send 4 words with no `in_last` → `error`=1 after the 16th byte; `in_ready` stays 0; a fifth `in_valid` is ignored; `cpu_reset` stays 1.
- **Reset mid-WRITE:** `reset` asserted at `bc`=2 → `mem_we` drops immediately; a following `start` reloads from address 0 with `word_count` starting again from 0.
- **Reload:** `start` while in DONE → `cpu_reset`=1 on the next edge; a second program overwrites address 0 onward.
